mem_port_arbiter: RTL

//  Shares one single-port synchronous RAM between two requesters:

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous RAM between two requesters: port 0
//   (accumulator controller reads) and port 1 (host loader writes/reads).
//   One transaction is in flight at a time and ties are broken round-robin.
//
// Handshake (both ports): the requester raises reqN and holds rwN/addrN/wdataN
//   stable until ackN. The arbiter latches the command when it grants, so a
//   req that drops before ack still completes and still gets its ack pulse.
//   ackN is a single-cycle completion pulse. rvalidN rides with ackN on reads
//   only, and rdata is valid while rvalidN is high. A req that is still high in
//   the cycle after ack is treated as a new request.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req0/1, rw0/1     request, 1 = read / 0 = write
//   addr0/1, wdata0/1 command address and write data
//   gnt0/1            granted port, high in ISSUE, WAIT and RESP
//   ack0/1, rvalid0/1 completion pulse, read-data-valid pulse
//   rdata             read data, held between reads
//   mem_en/rw/addr/wdata  RAM command; mem_en is high only in ISSUE
//   mem_rdata         RAM read data, valid RD_LAT cycles after mem_en
//   fsm_state         current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// RD_LAT must be 1..4. The WAIT down-counter is two bits wide.
module mem_port_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int CW = 2;

  state_t        state;
  state_t        state_nxt;
  logic          sel;        // granted port: 0 or 1
  logic          lat_rw;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          rr_last;    // port granted most recently
  logic [CW-1:0] cnt;
  logic [DW-1:0] rdata_q;
  logic          any_req;
  logic          pick;

  assign any_req = req0 | req1;
  // On a tie, the port that was not granted last time wins.
  // Otherwise the only requester wins.
  assign pick    = (req0 & req1) ? ~rr_last : req1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = lat_rw ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, round-robin pointer, WAIT counter and read-data register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel       <= 1'b0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rr_last   <= 1'b1;
      cnt       <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            sel       <= pick;
            rr_last   <= pick;
            lat_rw    <= pick ? rw1    : rw0;
            lat_addr  <= pick ? addr1  : addr0;
            lat_wdata <= pick ? wdata1 : wdata0;
          end
        end
        S_ISSUE: cnt <= CW'(RD_LAT - 1);
        S_WAIT: begin
          // mem_rdata is valid in the last WAIT cycle, which is
          // RD_LAT cycles after the mem_en cycle.
          if (cnt == '0) rdata_q <= mem_rdata;
          else           cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state, so they clear together with the
  // asynchronous reset.
  always_comb begin
    gnt0      = (state != S_IDLE) & ~sel;
    gnt1      = (state != S_IDLE) &  sel;
    ack0      = (state == S_RESP) & ~sel;
    ack1      = (state == S_RESP) &  sel;
    rvalid0   = (state == S_RESP) & ~sel & lat_rw;
    rvalid1   = (state == S_RESP) &  sel & lat_rw;
    rdata     = rdata_q;
    mem_en    = (state == S_ISSUE);
    mem_rw    = lat_rw;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    fsm_state = state;
  end

endmodule
